// File: rtl/bird_pkg.sv
// Shared definitions for the bird frame controller: sprite and screen
// defaults, coordinate type and the controller state encoding.
package bird_pkg;

    localparam int unsigned COORD_W   = 11;

    localparam int unsigned DEF_SPR_W = 34;
    localparam int unsigned DEF_SPR_H = 24;
    localparam int unsigned DEF_SCR_W = 640;
    localparam int unsigned DEF_SCR_H = 480;

    localparam int unsigned SPR_PIX   = DEF_SPR_W * DEF_SPR_H;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ERASE_RUN = 3'd1,
        ST_ERASE_REL = 3'd2,
        ST_DRAW_RUN  = 3'd3,
        ST_DRAW_REL  = 3'd4
    } bird_state_e;

    // True in the states where the drawer is being started and streams pixels.
    function automatic logic is_run(input bird_state_e st);
        return (st == ST_ERASE_RUN) || (st == ST_DRAW_RUN);
    endfunction

endpackage

// File: rtl/bird_frame_ctrl_fb_clip_reg.sv
// Registered write-qualification and clip stage: turns the drawer's
// unqualified pixel stream into framebuffer writes one cycle later.
import bird_pkg::*;

module fb_clip_reg #(
    parameter int unsigned SCR_W = DEF_SCR_W,
    parameter int unsigned SCR_H = DEF_SCR_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid_i,
    input  logic               color_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic               pass_i,
    output logic               fb_we_o,
    output logic [COORD_W-1:0] fb_x_o,
    output logic [COORD_W-1:0] fb_y_o,
    output logic               fb_color_o
);

    localparam coord_t X_LIM = coord_t'(SCR_W);
    localparam coord_t Y_LIM = coord_t'(SCR_H);

    logic   we_q, we_d;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   color_q, color_d;

    // Qualify: in-window pixel, set template bit, on screen. Colour is the pass.
    always_comb begin
        we_d    = pix_valid_i && color_i && (x_i < X_LIM) && (y_i < Y_LIM);
        x_d     = x_i;
        y_d     = y_i;
        color_d = pass_i;
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= 1'b0;
        end else begin
            we_q    <= we_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
        end
    end

    assign fb_we_o    = we_q;
    assign fb_x_o     = x_q;
    assign fb_y_o     = y_q;
    assign fb_color_o = color_q;

endmodule

// File: rtl/bird_frame_ctrl.sv
// Bird frame controller: on each frame tick erases the bird at its old
// position and redraws it at the new one through a start/done sprite drawer.
import bird_pkg::*;

module bird_frame_ctrl #(
    parameter int unsigned SPR_W = DEF_SPR_W,
    parameter int unsigned SPR_H = DEF_SPR_H,
    parameter int unsigned SCR_W = DEF_SCR_W,
    parameter int unsigned SCR_H = DEF_SCR_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    output logic               drw_start,
    output logic [COORD_W-1:0] drw_x,
    output logic [COORD_W-1:0] drw_y,
    input  logic               drw_done,
    input  logic [COORD_W-1:0] drw_px_x,
    input  logic [COORD_W-1:0] drw_px_y,
    input  logic               drw_color,
    output logic               fb_we,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic               fb_color,
    output logic               busy
);

    localparam int unsigned NPIX = SPR_W * SPR_H;
    localparam int unsigned KW   = $clog2(NPIX + 2);
    localparam logic [KW-1:0] K_LAST = KW'(NPIX);
    localparam logic [KW-1:0] K_MAX  = KW'(NPIX + 1);

    bird_state_e   state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    coord_t        new_x_q, new_x_d, new_y_q, new_y_d;
    coord_t        old_x_q, old_x_d, old_y_q, old_y_d;
    logic          old_valid_q, old_valid_d;
    logic          pending_q, pending_d;
    logic          busy_q, busy_d;
    logic          drw_start_q, drw_start_d;
    coord_t        drw_x_q, drw_x_d, drw_y_q, drw_y_d;

    logic          pix_valid;
    logic          pass_draw;

    // Next-state, pixel counter, position bookkeeping and pending-tick logic.
    always_comb begin
        state_d     = state_q;
        k_d         = '0;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        old_x_d     = old_x_q;
        old_y_d     = old_y_q;
        old_valid_d = old_valid_q;
        pending_d   = pending_q;
        drw_x_d     = drw_x_q;
        drw_y_d     = drw_y_q;

        if (frame_tick && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_tick || pending_q) begin
                    new_x_d   = pos_x;
                    new_y_d   = pos_y;
                    pending_d = 1'b0;
                    if (old_valid_q) begin
                        state_d = ST_ERASE_RUN;
                        drw_x_d = old_x_q;
                        drw_y_d = old_y_q;
                    end else begin
                        state_d = ST_DRAW_RUN;
                        drw_x_d = pos_x;
                        drw_y_d = pos_y;
                    end
                end
            end
            ST_ERASE_RUN: begin
                if (drw_done) state_d = ST_ERASE_REL;
            end
            ST_ERASE_REL: begin
                if (!drw_done) begin
                    state_d = ST_DRAW_RUN;
                    drw_x_d = new_x_q;
                    drw_y_d = new_y_q;
                end
            end
            ST_DRAW_RUN: begin
                if (drw_done) state_d = ST_DRAW_REL;
            end
            ST_DRAW_REL: begin
                if (!drw_done) begin
                    state_d     = ST_IDLE;
                    old_x_d     = new_x_q;
                    old_y_d     = new_y_q;
                    old_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // k restarts at 0 on every RUN entry and saturates one past the last pixel.
        if (is_run(state_q) && (state_d == state_q)) begin
            k_d = (k_q == K_MAX) ? K_MAX : k_q + 1'b1;
        end

        drw_start_d = is_run(state_d);
        // A pending tick keeps busy asserted through the IDLE cycle that services it.
        busy_d      = (state_d != ST_IDLE) || pending_d;
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            new_x_q     <= '0;
            new_y_q     <= '0;
            old_x_q     <= '0;
            old_y_q     <= '0;
            old_valid_q <= 1'b0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            drw_start_q <= 1'b0;
            drw_x_q     <= '0;
            drw_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
            old_x_q     <= old_x_d;
            old_y_q     <= old_y_d;
            old_valid_q <= old_valid_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            drw_start_q <= drw_start_d;
            drw_x_q     <= drw_x_d;
            drw_y_q     <= drw_y_d;
        end
    end

    assign pix_valid = is_run(state_q) && (k_q != '0) && (k_q <= K_LAST);
    assign pass_draw = (state_q == ST_DRAW_RUN);

    fb_clip_reg #(
        .SCR_W (SCR_W),
        .SCR_H (SCR_H)
    ) u_clip (
        .clk         (clk),
        .reset       (reset),
        .pix_valid_i (pix_valid),
        .color_i     (drw_color),
        .x_i         (drw_px_x),
        .y_i         (drw_px_y),
        .pass_i      (pass_draw),
        .fb_we_o     (fb_we),
        .fb_x_o      (fb_x),
        .fb_y_o      (fb_y),
        .fb_color_o  (fb_color)
    );

    assign drw_start = drw_start_q;
    assign drw_x     = drw_x_q;
    assign drw_y     = drw_y_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bird_frame_ctrl.sv
// Testbench for bird_frame_ctrl: behavioural sprite drawer plus a
// scoreboard of expected framebuffer writes.
module tb_bird_frame_ctrl;
    import bird_pkg::*;

    localparam int W  = DEF_SPR_W;
    localparam int H  = DEF_SPR_H;
    localparam int SW = DEF_SCR_W;
    localparam int SH = DEF_SCR_H;
    localparam int NP = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [10:0] pos_x, pos_y;
    logic        drw_start;
    logic [10:0] drw_x, drw_y;
    logic        drw_done = 1'b0;
    logic [10:0] drw_px_x, drw_px_y;
    logic        drw_color;
    logic        fb_we;
    logic [10:0] fb_x, fb_y;
    logic        fb_color;
    logic        busy;

    bird_frame_ctrl #(.SPR_W(W), .SPR_H(H), .SCR_W(SW), .SCR_H(SH)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .drw_start  (drw_start),
        .drw_x      (drw_x),
        .drw_y      (drw_y),
        .drw_done   (drw_done),
        .drw_px_x   (drw_px_x),
        .drw_px_y   (drw_px_y),
        .drw_color  (drw_color),
        .fb_we      (fb_we),
        .fb_x       (fb_x),
        .fb_y       (fb_y),
        .fb_color   (fb_color),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic tmpl(input int r, input int c);
        return ((r * 5 + c * 3) % 7) < 4;
    endfunction

    // Sprite drawer model: pixel idx streams at count idx+1, done after the last.
    int dcnt = 0;
    always @(posedge clk) begin
        if (!drw_start) begin
            dcnt     <= 0;
            drw_done <= 1'b0;
        end else begin
            if (dcnt <= NP) dcnt <= dcnt + 1;
            drw_done <= (dcnt >= NP);
        end
    end

    // Outside the pixel window the drawer drives junk that must never be written.
    always_comb begin
        int didx, dr, dc;
        didx = 0; dr = 0; dc = 0;
        drw_px_x  = drw_x;
        drw_px_y  = drw_y;
        drw_color = 1'b1;
        if (dcnt >= 1 && dcnt <= NP) begin
            didx      = dcnt - 1;
            dr        = didx / W;
            dc        = didx % W;
            drw_px_x  = drw_x + 11'(dc);
            drw_px_y  = drw_y + 11'(dr);
            drw_color = tmpl(dr, dc);
        end
    end

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
    } wr_t;

    typedef struct {
        logic [10:0] x;
        logic [10:0] y;
        logic        erase;
        int          writes;
    } vec_t;

    wr_t  expq[$];
    vec_t vecs[5];
    int   n_cmp = 0, n_fail = 0;
    int   wr_cnt = 0, oob_cnt = 0, n_falls = 0;
    logic busy_prev = 1'b0;
    logic [10:0] old_x, old_y;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    function automatic int count_box(input logic [10:0] ox, input logic [10:0] oy);
        int n = 0;
        logic [10:0] px, py;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                px = ox + 11'(c);
                py = oy + 11'(r);
                if (tmpl(r, c) && px < 11'(SW) && py < 11'(SH)) n++;
            end
        return n;
    endfunction

    task automatic push_box(input logic [10:0] ox, input logic [10:0] oy, input logic col);
        wr_t e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                e.x = ox + 11'(c);
                e.y = oy + 11'(r);
                e.c = col;
                if (tmpl(r, c) && e.x < 11'(SW) && e.y < 11'(SH)) expq.push_back(e);
            end
    endtask

    task automatic check_write();
        wr_t got, e;
        got.x = fb_x; got.y = fb_y; got.c = fb_color;
        wr_cnt++;
        n_cmp++;
        if (fb_x >= 11'(SW) || fb_y >= 11'(SH)) oob_cnt++;
        if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL fb_write: got x=%0d y=%0d c=%0d, required no write", fb_x, fb_y, fb_color);
        end else begin
            e = expq.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL fb_write: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                         fb_x, fb_y, fb_color, e.x, e.y, e.c);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (fb_we) check_write();
        if (busy_prev && !busy) n_falls++;
        busy_prev = busy;
    endtask

    task automatic wait_idle(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            step();
            if (!busy) break;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic pulse_tick(input logic [10:0] x, input logic [10:0] y);
        pos_x = x; pos_y = y;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic do_frame(input vec_t v);
        wr_cnt = 0;
        if (v.erase) push_box(old_x, old_y, 1'b0);
        push_box(v.x, v.y, 1'b1);
        pulse_tick(v.x, v.y);
        chk("busy_rise", 32'(busy), 32'd1);
        chk("start_rise", 32'(drw_start), 32'd1);
        chk("drw_x", 32'(drw_x), v.erase ? 32'(old_x) : 32'(v.x));
        wait_idle(4000, "frame_idle");
        chk("queue_drained", 32'(expq.size()), 32'd0);
        chk("write_count", 32'(wr_cnt), 32'(v.writes));
        chk("start_low", 32'(drw_start), 32'd0);
        old_x = v.x; old_y = v.y;
    endtask

    initial begin
        vecs[0] = '{x: 11'd100, y: 11'd100, erase: 1'b0, writes: 0};
        vecs[1] = '{x: 11'd120, y: 11'd90,  erase: 1'b1, writes: 0};
        vecs[2] = '{x: 11'd630, y: 11'd470, erase: 1'b1, writes: 0};
        vecs[3] = '{x: 11'd0,   y: 11'd0,   erase: 1'b1, writes: 0};
        vecs[4] = '{x: 11'd606, y: 11'd456, erase: 1'b1, writes: 0};
        for (int i = 0; i < 5; i++) begin
            vecs[i].writes = count_box(vecs[i].x, vecs[i].y);
            if (vecs[i].erase) vecs[i].writes += count_box(vecs[i-1].x, vecs[i-1].y);
        end

        reset = 1'b1; frame_tick = 1'b0; pos_x = '0; pos_y = '0;
        old_x = '0; old_y = '0;
        repeat (3) step();
        chk("rst_drw_start", 32'(drw_start), 32'd0);
        chk("rst_drw_x", 32'(drw_x), 32'd0);
        chk("rst_drw_y", 32'(drw_y), 32'd0);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_x", 32'(fb_x), 32'd0);
        chk("rst_fb_y", 32'(fb_y), 32'd0);
        chk("rst_fb_color", 32'(fb_color), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 5; i++) do_frame(vecs[i]);

        // Three ticks during a busy update: one extra update with pos sampled late.
        push_box(old_x, old_y, 1'b0);
        push_box(11'd200, 11'd200, 1'b1);
        push_box(11'd200, 11'd200, 1'b0);
        push_box(11'd300, 11'd150, 1'b1);
        n_falls = 0;
        pulse_tick(11'd200, 11'd200);
        chk("pend_busy_rise", 32'(busy), 32'd1);
        repeat (1000) step();
        pos_x = 11'd250; pos_y = 11'd250;
        for (int t = 0; t < 3; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            repeat (5) step();
        end
        pos_x = 11'd300; pos_y = 11'd150;
        wait_idle(10000, "pend_idle");
        chk("pend_queue_drained", 32'(expq.size()), 32'd0);
        chk("pend_busy_falls", 32'(n_falls), 32'd1);
        old_x = 11'd300; old_y = 11'd150;
        repeat (3) step();
        chk("pend_no_extra", 32'(busy), 32'd0);

        // Reset in the middle of an erase pass.
        push_box(old_x, old_y, 1'b0);
        pulse_tick(11'd50, 11'd60);
        repeat (200) step();
        chk("erase_running", 32'(drw_start), 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_start", 32'(drw_start), 32'd0);
        chk("mid_rst_fb_we", 32'(fb_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        expq.delete();
        repeat (3) step();
        do_frame('{x: 11'd80, y: 11'd70, erase: 1'b0, writes: count_box(11'd80, 11'd70)});

        chk("no_off_screen", 32'(oob_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
